euler_integrator: RTL and testbench

Semi-implicit Euler time-step engine for the gravity simulator. Once the force stage has filled the per-body acceleration registers, this block updates every active body in the shared register file: first `vel += acc*dt`, then `pos += vel_new*dt`. It runs as a register-file client on the same 6-address read/write port convention as the force FSM. The renderer consumes the updated positions on the next frame.

---
 rtl/gravsim_pkg.sv | 59 +++++
 rtl/fx_mul_add_sat.sv | 29 ++
 rtl/euler_integrator.sv | 230 +++++++++++++++++++++++
 tb/tb_euler_integrator.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gravsim_pkg.sv
// gravsim_pkg: shared definitions for the gravity-simulator register-file
// clients.
//   - Default body-slot count and Q16.16 fractional width.
//   - Per-variable bank offsets. Body i (1-based) of a bank lives at offset+i.
//   - The register-file enable encoding used on RF_RE / RF_WE.
//   - The integrator state enum.
//   - A 65-bit to 32-bit signed saturation helper.
package gravsim_pkg;

    localparam int MAX_BODIES = 10;
    localparam int FRAC       = 16;

    localparam logic [31:0] OFFSET_POS_X = 32'd23;
    localparam logic [31:0] OFFSET_POS_Y = 32'd33;
    localparam logic [31:0] OFFSET_POS_Z = 32'd43;
    localparam logic [31:0] OFFSET_VEL_X = 32'd53;
    localparam logic [31:0] OFFSET_VEL_Y = 32'd63;
    localparam logic [31:0] OFFSET_VEL_Z = 32'd73;
    localparam logic [31:0] OFFSET_ACC_X = 32'd83;
    localparam logic [31:0] OFFSET_ACC_Y = 32'd93;
    localparam logic [31:0] OFFSET_ACC_Z = 32'd103;

    // LO enables ports 1-3, HI enables ports 4-6
    typedef enum logic [1:0] {
        RF_EN_NONE = 2'd0,
        RF_EN_LO   = 2'd1,
        RF_EN_HI   = 2'd2,
        RF_EN_ALL  = 2'd3
    } rf_en_t;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_VA   = 4'd1,
        ST_WAIT_VA = 4'd2,
        ST_MUL_V   = 4'd3,
        ST_WR_V    = 4'd4,
        ST_RD_P    = 4'd5,
        ST_WAIT_P  = 4'd6,
        ST_MUL_P   = 4'd7,
        ST_WR_P    = 4'd8,
        ST_DONE    = 4'd9
    } integ_state_t;

    localparam logic signed [64:0] SAT_MAX_65 = 65'sh0_7FFF_FFFF;
    localparam logic signed [64:0] SAT_MIN_65 = 65'sh1_FFFF_FFFF_8000_0000;

    function automatic logic [31:0] sat32(input logic signed [64:0] v);
        logic [31:0] r;
        if (v > SAT_MAX_65) begin
            r = 32'h7FFF_FFFF;
        end else if (v < SAT_MIN_65) begin
            r = 32'h8000_0000;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fx_mul_add_sat.sv
// fx_mul_add_sat: combinational Q-format step  res = sat(base + sat((x*dt)>>>FRAC)).
//   x_i, dt_i, base_i : signed 32-bit fixed-point operands
//   res_o             : saturated signed 32-bit result
// The product is a full 64-bit signed result. The shift floors toward -inf.
module fx_mul_add_sat #(
    parameter int FRAC = gravsim_pkg::FRAC
) (
    input  logic [31:0] x_i,
    input  logic [31:0] dt_i,
    input  logic [31:0] base_i,
    output logic [31:0] res_o
);
    import gravsim_pkg::sat32;

    logic signed [63:0] prod_s;
    logic signed [63:0] shr_s;
    logic [31:0]        scaled_s;
    logic signed [32:0] sum_s;

    // Multiply, rescale, saturate the increment, then add and saturate again
    always_comb begin
        prod_s   = $signed({{32{x_i[31]}}, x_i}) * $signed({{32{dt_i[31]}}, dt_i});
        shr_s    = prod_s >>> FRAC;
        scaled_s = sat32({shr_s[63], shr_s});
        sum_s    = $signed({base_i[31], base_i}) + $signed({scaled_s[31], scaled_s});
        res_o    = sat32({{32{sum_s[32]}}, sum_s});
    end

endmodule

// File: rtl/euler_integrator.sv
// euler_integrator: semi-implicit Euler step over bodies 1..N of the shared
// register file. For each body it computes vel += acc*DT and then
// pos += vel_new*DT.
//   CLK, RESET            : clock and synchronous active-high reset
//   START, NUM, DT        : step request (level), body count, Q16.16 time step
//   BUSY, DONE            : run status; DONE holds until START drops
//   RF_RE, RF_WE          : enables (0 none, 1 ports 1-3, 2 ports 4-6, 3 all)
//   RF_ADDR*, RF_WDATA*   : register-file addresses and write data
//   RF_RDATA*             : read data, valid two cycles after the read cycle
// All outputs are registers, loaded from a decode of the next state.
// They therefore change together with the state.
module euler_integrator #(
    parameter int MAX_BODIES = gravsim_pkg::MAX_BODIES,
    parameter int FRAC       = gravsim_pkg::FRAC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] NUM,
    input  logic [31:0] DT,
    output logic        BUSY,
    output logic        DONE,
    output logic [1:0]  RF_RE,
    output logic [1:0]  RF_WE,
    output logic [31:0] RF_ADDR1,
    output logic [31:0] RF_ADDR2,
    output logic [31:0] RF_ADDR3,
    output logic [31:0] RF_ADDR4,
    output logic [31:0] RF_ADDR5,
    output logic [31:0] RF_ADDR6,
    output logic [31:0] RF_WDATA1,
    output logic [31:0] RF_WDATA2,
    output logic [31:0] RF_WDATA3,
    output logic [31:0] RF_WDATA4,
    output logic [31:0] RF_WDATA5,
    output logic [31:0] RF_WDATA6,
    input  logic [31:0] RF_RDATA1,
    input  logic [31:0] RF_RDATA2,
    input  logic [31:0] RF_RDATA3,
    input  logic [31:0] RF_RDATA4,
    input  logic [31:0] RF_RDATA5,
    input  logic [31:0] RF_RDATA6
);
    import gravsim_pkg::*;

    localparam logic [31:0] MAX_BODIES_W = 32'(MAX_BODIES);

    integ_state_t     state_q, state_d;
    logic [31:0]      n_q, n_d, dt_q, dt_d, idx_q, idx_d;
    logic [2:0][31:0] vel_q, vel_d;
    logic             busy_q, busy_d, done_q, done_d;
    rf_en_t           re_q, re_d, we_q, we_d;
    logic [5:0][31:0] addr_q, addr_d, wdata_q, wdata_d;

    logic [5:0][31:0] rdata_s;
    logic [31:0]      num_clamp_s;
    logic [31:0]      mul_x_s [3];
    logic [31:0]      res_s [3];

    assign rdata_s     = {RF_RDATA6, RF_RDATA5, RF_RDATA4, RF_RDATA3, RF_RDATA2, RF_RDATA1};
    assign num_clamp_s = (NUM > MAX_BODIES_W) ? MAX_BODIES_W : NUM;

    // Operand mux: the multiplier takes ACC in MUL_V and the held v' in
    // MUL_P. The addend is always read port 1-3: VEL in MUL_V, POS in MUL_P.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            if (state_q == ST_MUL_V) begin
                mul_x_s[k] = rdata_s[k + 3];
            end else begin
                mul_x_s[k] = vel_q[k];
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_axis
        fx_mul_add_sat #(.FRAC(FRAC)) u_fx (
            .x_i    (mul_x_s[k]),
            .dt_i   (dt_q),
            .base_i (rdata_s[k]),
            .res_o  (res_s[k])
        );
    end

    // Next-state logic, latching N/DT at start and capturing v' in MUL_V
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        dt_d    = dt_q;
        idx_d   = idx_q;
        vel_d   = vel_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    n_d   = num_clamp_s;
                    dt_d  = DT;
                    idx_d = 32'd1;
                    if (num_clamp_s == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD_VA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_VA:   state_d = ST_WAIT_VA;
            ST_WAIT_VA: state_d = ST_MUL_V;
            ST_MUL_V: begin
                vel_d   = {res_s[2], res_s[1], res_s[0]};
                state_d = ST_WR_V;
            end
            ST_WR_V:    state_d = ST_RD_P;
            ST_RD_P:    state_d = ST_WAIT_P;
            ST_WAIT_P:  state_d = ST_MUL_P;
            ST_MUL_P:   state_d = ST_WR_P;
            ST_WR_P: begin
                if (idx_q == n_q) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 32'd1;
                    state_d = ST_RD_VA;
                end
            end
            ST_DONE: begin
                if (!START) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        re_d    = RF_EN_NONE;
        we_d    = RF_EN_NONE;
        addr_d  = {6{32'd0}};
        wdata_d = {6{32'd0}};
        case (state_d)
            ST_RD_VA: begin
                busy_d    = 1'b1;
                re_d      = RF_EN_ALL;
                addr_d[0] = OFFSET_VEL_X + idx_d;
                addr_d[1] = OFFSET_VEL_Y + idx_d;
                addr_d[2] = OFFSET_VEL_Z + idx_d;
                addr_d[3] = OFFSET_ACC_X + idx_d;
                addr_d[4] = OFFSET_ACC_Y + idx_d;
                addr_d[5] = OFFSET_ACC_Z + idx_d;
            end
            ST_WR_V: begin
                busy_d    = 1'b1;
                we_d      = RF_EN_LO;
                addr_d[0] = OFFSET_VEL_X + idx_d;
                addr_d[1] = OFFSET_VEL_Y + idx_d;
                addr_d[2] = OFFSET_VEL_Z + idx_d;
                for (int k = 0; k < 3; k++) wdata_d[k] = vel_d[k];
            end
            ST_RD_P: begin
                busy_d    = 1'b1;
                re_d      = RF_EN_LO;
                addr_d[0] = OFFSET_POS_X + idx_d;
                addr_d[1] = OFFSET_POS_Y + idx_d;
                addr_d[2] = OFFSET_POS_Z + idx_d;
            end
            ST_WR_P: begin
                busy_d    = 1'b1;
                we_d      = RF_EN_LO;
                addr_d[0] = OFFSET_POS_X + idx_d;
                addr_d[1] = OFFSET_POS_Y + idx_d;
                addr_d[2] = OFFSET_POS_Z + idx_d;
                for (int k = 0; k < 3; k++) wdata_d[k] = res_s[k];
            end
            ST_WAIT_VA, ST_MUL_V, ST_WAIT_P, ST_MUL_P: busy_d = 1'b1;
            ST_DONE: done_d = 1'b1;
            ST_IDLE: done_d = 1'b0;
            default: done_d = 1'b0;
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            n_q     <= 32'd0;
            dt_q    <= 32'd0;
            idx_q   <= 32'd0;
            vel_q   <= {3{32'd0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            re_q    <= RF_EN_NONE;
            we_q    <= RF_EN_NONE;
            addr_q  <= {6{32'd0}};
            wdata_q <= {6{32'd0}};
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            dt_q    <= dt_d;
            idx_q   <= idx_d;
            vel_q   <= vel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            re_q    <= re_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RF_RE     = re_q;
    assign RF_WE     = we_q;
    assign RF_ADDR1  = addr_q[0];
    assign RF_ADDR2  = addr_q[1];
    assign RF_ADDR3  = addr_q[2];
    assign RF_ADDR4  = addr_q[3];
    assign RF_ADDR5  = addr_q[4];
    assign RF_ADDR6  = addr_q[5];
    assign RF_WDATA1 = wdata_q[0];
    assign RF_WDATA2 = wdata_q[1];
    assign RF_WDATA3 = wdata_q[2];
    assign RF_WDATA4 = wdata_q[3];
    assign RF_WDATA5 = wdata_q[4];
    assign RF_WDATA6 = wdata_q[5];

endmodule

// File: tb/tb_euler_integrator.sv
// tb_euler_integrator: directed, table-driven bench for euler_integrator with
// a behavioural register file (2-cycle read latency) and a memory scoreboard.
module tb_euler_integrator;

    localparam int OFF_POS = 23;
    localparam int OFF_VEL = 53;
    localparam int OFF_ACC = 83;

    logic        CLK = 1'b0;
    logic        RESET, START, load_req;
    logic [31:0] NUM, DT;
    logic        BUSY, DONE;
    logic [1:0]  RF_RE, RF_WE;
    logic [31:0] rf_addr [6];
    logic [31:0] rf_wdata [6];
    logic [31:0] rf_rdata [6];
    logic [31:0] rf_stage [6];
    logic [31:0] mem [128];
    logic [31:0] init_img [128];
    logic [31:0] exp_mem [128];
    int re_cnt = 0;
    int we_cnt = 0;
    int excl_err = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0]      dt;
        logic [2:0][31:0] vel, acc, pos, ev, ep;
    } vec_t;

    euler_integrator dut (
        .CLK(CLK), .RESET(RESET), .START(START), .NUM(NUM), .DT(DT),
        .BUSY(BUSY), .DONE(DONE), .RF_RE(RF_RE), .RF_WE(RF_WE),
        .RF_ADDR1(rf_addr[0]), .RF_ADDR2(rf_addr[1]), .RF_ADDR3(rf_addr[2]),
        .RF_ADDR4(rf_addr[3]), .RF_ADDR5(rf_addr[4]), .RF_ADDR6(rf_addr[5]),
        .RF_WDATA1(rf_wdata[0]), .RF_WDATA2(rf_wdata[1]), .RF_WDATA3(rf_wdata[2]),
        .RF_WDATA4(rf_wdata[3]), .RF_WDATA5(rf_wdata[4]), .RF_WDATA6(rf_wdata[5]),
        .RF_RDATA1(rf_rdata[0]), .RF_RDATA2(rf_rdata[1]), .RF_RDATA3(rf_rdata[2]),
        .RF_RDATA4(rf_rdata[3]), .RF_RDATA5(rf_rdata[4]), .RF_RDATA6(rf_rdata[5])
    );

    always #10 CLK = ~CLK;

    // Register-file model: writes, two-stage read pipeline, activity monitor
    always @(posedge CLK) begin
        if (load_req) begin
            for (int a = 0; a < 128; a++) mem[a] <= init_img[a];
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (RF_WE[k / 3]) mem[rf_addr[k][6:0]] <= rf_wdata[k];
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (RF_RE[k / 3]) rf_stage[k] <= mem[rf_addr[k][6:0]];
            rf_rdata[k] <= rf_stage[k];
        end
        if (RF_RE != 2'd0) re_cnt <= re_cnt + 1;
        if (RF_WE != 2'd0) we_cnt <= we_cnt + 1;
        if (RF_RE != 2'd0 && RF_WE != 2'd0) excl_err <= excl_err + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0][31:0] vec3(input logic [31:0] x, input logic [31:0] y,
                                              input logic [31:0] z);
        return {z, y, x};
    endfunction

    task automatic clear_img();
        for (int a = 0; a < 128; a++) begin
            init_img[a] = 32'hA5A5_0000 + 32'(a);
            exp_mem[a]  = 32'hA5A5_0000 + 32'(a);
        end
    endtask

    task automatic set_body(input int i, input logic [2:0][31:0] v, input logic [2:0][31:0] a,
                            input logic [2:0][31:0] p);
        for (int k = 0; k < 3; k++) begin
            init_img[OFF_VEL + 10 * k + i] = v[k];
            exp_mem[OFF_VEL + 10 * k + i]  = v[k];
            init_img[OFF_ACC + 10 * k + i] = a[k];
            exp_mem[OFF_ACC + 10 * k + i]  = a[k];
            init_img[OFF_POS + 10 * k + i] = p[k];
            exp_mem[OFF_POS + 10 * k + i]  = p[k];
        end
    endtask

    task automatic set_exp(input int off, input int i, input logic [2:0][31:0] v);
        for (int k = 0; k < 3; k++) exp_mem[off + 10 * k + i] = v[k];
    endtask

    task automatic load_img();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic check_mem(input string name);
        for (int a = 0; a < 128; a++) chk($sformatf("%s_mem[%0d]", name, a), mem[a], exp_mem[a]);
    endtask

    // Runs one step and checks DONE latency, BUSY length and RE/WE cycle counts.
    // START is left high on return unless drop_start was set.
    task automatic run_step(input string name, input logic [31:0] num, input logic [31:0] dt,
                            input int exp_ticks, input bit drop_start, input int exp_acc);
        int t;
        int busy_n;
        int re0;
        int we0;
        t = 0;
        busy_n = 0;
        re0 = re_cnt;
        we0 = we_cnt;
        NUM = num;
        DT = dt;
        START = 1'b1;
        do begin
            tick();
            t++;
            if (BUSY) busy_n++;
            if (drop_start) begin
                START = 1'b0;
                NUM = 32'd1;
                DT = 32'd0;
            end
        end while (!DONE && t < 200);
        chk({name, "_done_ticks"}, 32'(t), 32'(exp_ticks));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_ticks - 1));
        chk({name, "_re_cycles"}, 32'(re_cnt - re0), 32'(exp_acc));
        chk({name, "_we_cycles"}, 32'(we_cnt - we0), 32'(exp_acc));
    endtask

    task automatic setup_three();
        clear_img();
        set_body(1, vec3(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000),
                    vec3(32'h0002_0000, 32'h0000_0000, 32'hFFFE_0000),
                    vec3(32'h0000_0000, 32'h0001_0000, 32'h0003_0000));
        set_body(2, vec3(32'h0000_0000, 32'h0000_0000, 32'h0000_0000),
                    vec3(32'h0004_0000, 32'hFFFC_0000, 32'h0001_0000),
                    vec3(32'h0005_0000, 32'h0000_0000, 32'hFFFF_0000));
        set_body(3, vec3(32'h0000_8000, 32'h0003_0000, 32'h0000_0000),
                    vec3(32'h0001_0000, 32'h0000_0000, 32'h0000_0003),
                    vec3(32'h0010_0000, 32'hFFF0_0000, 32'h0000_0007));
    endtask

    initial begin
        vec_t vecs [4];
        int re0;
        int we0;

        vecs[0].dt = 32'h0001_0000;
        vecs[0].vel = vec3(32'h0001_0000, 32'h0, 32'h0);
        vecs[0].acc = vec3(32'h0000_8000, 32'h0, 32'h0);
        vecs[0].pos = vec3(32'h000A_0000, 32'h0, 32'h0);
        vecs[0].ev  = vec3(32'h0001_8000, 32'h0, 32'h0);
        vecs[0].ep  = vec3(32'h000B_8000, 32'h0, 32'h0);
        vecs[1].dt = 32'h0001_0000;
        vecs[1].vel = vec3(32'h7FFF_0000, 32'h8001_0000, 32'h0);
        vecs[1].acc = vec3(32'h0010_0000, 32'hFFF0_0000, 32'h0);
        vecs[1].pos = vec3(32'h0, 32'h0, 32'h1234_5678);
        vecs[1].ev  = vec3(32'h7FFF_FFFF, 32'h8000_0000, 32'h0);
        vecs[1].ep  = vec3(32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678);
        vecs[2].dt = 32'h0000_8000;
        vecs[2].vel = vec3(32'h0, 32'h0, 32'h0001_0000);
        vecs[2].acc = vec3(32'hFFFF_FFFF, 32'h0000_0001, 32'h0003_0000);
        vecs[2].pos = vec3(32'h0, 32'h0000_0005, 32'h0004_0000);
        vecs[2].ev  = vec3(32'hFFFF_FFFF, 32'h0, 32'h0002_8000);
        vecs[2].ep  = vec3(32'hFFFF_FFFF, 32'h0000_0005, 32'h0005_4000);
        vecs[3].dt = 32'h0010_0000;
        vecs[3].vel = vec3(32'hC000_0000, 32'hFFFF_0000, 32'h0);
        vecs[3].acc = vec3(32'h4000_0000, 32'h0, 32'h0);
        vecs[3].pos = vec3(32'h0, 32'h0020_0000, 32'h0);
        vecs[3].ev  = vec3(32'h3FFF_FFFF, 32'hFFFF_0000, 32'h0);
        vecs[3].ep  = vec3(32'h7FFF_FFFF, 32'h0010_0000, 32'h0);

        RESET = 1'b1;
        START = 1'b0;
        load_req = 1'b0;
        NUM = 32'd0;
        DT = 32'd0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_re", {30'd0, RF_RE}, 32'd0);
        chk("rst_we", {30'd0, RF_WE}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rst_addr%0d", k + 1), rf_addr[k], 32'd0);
            chk($sformatf("rst_wdata%0d", k + 1), rf_wdata[k], 32'd0);
        end
        RESET = 1'b0;
        tick();

        // Single-body vectors
        for (int v = 0; v < 4; v++) begin
            clear_img();
            set_body(1, vecs[v].vel, vecs[v].acc, vecs[v].pos);
            set_exp(OFF_VEL, 1, vecs[v].ev);
            set_exp(OFF_POS, 1, vecs[v].ep);
            load_img();
            run_step($sformatf("vec%0d", v), 32'd1, vecs[v].dt, 9, 1'b0, 2);
            START = 1'b0;
            tick();
            chk($sformatf("vec%0d_idle_done", v), {31'd0, DONE}, 32'd0);
            check_mem($sformatf("vec%0d", v));
        end

        // Three bodies, START dropped and NUM/DT changed mid-run
        setup_three();
        set_exp(OFF_VEL, 1, vec3(32'h0002_0000, 32'h0002_0000, 32'hFFFE_0000));
        set_exp(OFF_POS, 1, vec3(32'h0001_0000, 32'h0002_0000, 32'h0002_0000));
        set_exp(OFF_VEL, 2, vec3(32'h0002_0000, 32'hFFFE_0000, 32'h0000_8000));
        set_exp(OFF_POS, 2, vec3(32'h0006_0000, 32'hFFFF_0000, 32'hFFFF_4000));
        set_exp(OFF_VEL, 3, vec3(32'h0001_0000, 32'h0003_0000, 32'h0000_0001));
        set_exp(OFF_POS, 3, vec3(32'h0010_8000, 32'hFFF1_8000, 32'h0000_0007));
        load_img();
        run_step("n3", 32'd3, 32'h0000_8000, 25, 1'b1, 6);
        tick();
        check_mem("n3");

        // NUM=0: immediate DONE, no register-file traffic
        clear_img();
        load_img();
        run_step("n0", 32'd0, 32'h0001_0000, 1, 1'b0, 0);
        START = 1'b0;
        tick();
        check_mem("n0");

        // NUM=15 clamps to 10 bodies
        clear_img();
        for (int i = 1; i <= 10; i++) begin
            set_body(i, vec3(32'h0, 32'h0, 32'h0), vec3(32'(i) << 16, 32'h0, 32'h0),
                     vec3(32'h0, 32'h0, 32'h0));
            set_exp(OFF_VEL, i, vec3(32'(i) << 16, 32'h0, 32'h0));
            set_exp(OFF_POS, i, vec3(32'(i) << 16, 32'h0, 32'h0));
        end
        load_img();
        run_step("n15", 32'd15, 32'h0001_0000, 81, 1'b0, 20);
        START = 1'b0;
        tick();
        check_mem("n15");

        // START held after DONE: no re-trigger; low then high runs again
        clear_img();
        set_body(1, vecs[0].vel, vecs[0].acc, vecs[0].pos);
        set_exp(OFF_VEL, 1, vecs[0].ev);
        set_exp(OFF_POS, 1, vecs[0].ep);
        load_img();
        run_step("hold1", 32'd1, 32'h0001_0000, 9, 1'b0, 2);
        re0 = re_cnt;
        we0 = we_cnt;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("hold_done_c%0d", c), {31'd0, DONE}, 32'd1);
            chk($sformatf("hold_busy_c%0d", c), {31'd0, BUSY}, 32'd0);
        end
        chk("hold_re_idle", 32'(re_cnt - re0), 32'd0);
        chk("hold_we_idle", 32'(we_cnt - we0), 32'd0);
        check_mem("hold1");
        START = 1'b0;
        tick();
        chk("hold_release_done", {31'd0, DONE}, 32'd0);
        run_step("hold2", 32'd1, 32'h0001_0000, 9, 1'b0, 2);
        START = 1'b0;
        tick();
        set_exp(OFF_VEL, 1, vec3(32'h0002_0000, 32'h0, 32'h0));
        set_exp(OFF_POS, 1, vec3(32'h000D_8000, 32'h0, 32'h0));
        check_mem("hold2");

        // RESET during body 2's RD_P: body 1 done, body 2 velocity only
        setup_three();
        set_exp(OFF_VEL, 1, vec3(32'h0002_0000, 32'h0002_0000, 32'hFFFE_0000));
        set_exp(OFF_POS, 1, vec3(32'h0001_0000, 32'h0002_0000, 32'h0002_0000));
        set_exp(OFF_VEL, 2, vec3(32'h0002_0000, 32'hFFFE_0000, 32'h0000_8000));
        load_img();
        NUM = 32'd3;
        DT = 32'h0000_8000;
        START = 1'b1;
        repeat (13) tick();
        chk("rstmid_rdp_re", {30'd0, RF_RE}, 32'd1);
        chk("rstmid_rdp_addr1", rf_addr[0], 32'd25);
        RESET = 1'b1;
        START = 1'b0;
        tick();
        chk("rstmid_busy", {31'd0, BUSY}, 32'd0);
        chk("rstmid_done", {31'd0, DONE}, 32'd0);
        chk("rstmid_re", {30'd0, RF_RE}, 32'd0);
        chk("rstmid_we", {30'd0, RF_WE}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rstmid_addr%0d", k + 1), rf_addr[k], 32'd0);
            chk($sformatf("rstmid_wdata%0d", k + 1), rf_wdata[k], 32'd0);
        end
        RESET = 1'b0;
        repeat (3) tick();
        chk("rstmid_stays_idle", {31'd0, BUSY}, 32'd0);
        check_mem("rstmid");

        chk("re_we_exclusive", 32'(excl_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
